// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory access path: size encodings,
// access-unit FSM states and the alignment rule.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Size 2'b11 falls through to the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Store lane steering: byte enables from size/offset and the store data
// replicated across every lane the access could land in.
module store_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Single-outstanding load/store stage in front of a fixed-latency synchronous
// data memory; traps misaligned accesses and right-aligns load data.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | memory strobe cycle (mem_en high)
// ST_WAIT  | load latency countdown, sample read data at zero
// ST_RESP  | one-cycle response pulse
module dmem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LOAD_CNT = 3'(MEM_LATENCY - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_off;

    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign req_ready    = (r_state == ST_IDLE);

    store_align u_store_align (
        .i_size  (req_size),
        .i_off   (req_addr[1:0]),
        .i_wdata (req_wdata),
        .o_be    (w_be),
        .o_wdata (w_wdata)
    );

    // Memory-side outputs are loaded on acceptance so they are registered
    // and valid for exactly the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_off      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we  <= req_we;
                        r_off <= req_addr[1:0];
                        if (w_misaligned) begin
                            r_state    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            r_state   <= ST_ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we ? w_be : 4'b0000;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        r_state    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= LOAD_CNT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_rdata >> {r_off, 3'b000};
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: latency-2 instance for loads/stores/traps,
// latency-4 instance for mid-operation reset.
module tb_dmem_access_unit;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: MEM_LATENCY = 2
    logic        a_rst, a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [1:0]  a_req_size;
    logic        a_resp_valid, a_resp_err, a_mem_en;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_we;
    logic [31:0] a_mem_data = 32'h0;
    logic [7:0]  a_pipe = '0;

    // Instance B: MEM_LATENCY = 4
    logic        b_rst, b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_size;
    logic        b_resp_valid, b_resp_err, b_mem_en;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_we;
    logic [31:0] b_mem_data = 32'h0;
    logic [7:0]  b_pipe = '0;

    // Memory model: read data is only valid exactly MEM_LATENCY cycles after mem_en.
    always @(posedge clk) a_pipe <= {a_pipe[6:0], a_mem_en};
    always @(posedge clk) b_pipe <= {b_pipe[6:0], b_mem_en};
    assign a_mem_rdata = a_pipe[1] ? a_mem_data : 32'h5A5A_5A5A;
    assign b_mem_rdata = b_pipe[3] ? b_mem_data : 32'h5A5A_5A5A;

    dmem_access_unit #(.MEM_LATENCY(2)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_size(a_req_size),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_access_unit #(.MEM_LATENCY(4)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Observations of one request on instance A, cycle k counted from acceptance.
    int          o_en_k, o_en_cnt, o_resp_k, o_ready_after, o_stray_we;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_we;
    logic        o_err;

    task automatic a_watch(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [31:0] mdata);
        o_en_k = 0; o_en_cnt = 0; o_resp_k = 0; o_ready_after = -1; o_stray_we = 0;
        o_addr = '0; o_we = '0; o_wdata = '0; o_rdata = 32'hFFFF_FFFF; o_err = 1'bx;
        a_mem_data  = mdata;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_size  = size;
        a_req_wdata = wdata;
        a_req_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            a_req_valid = 1'b0;
            if (a_mem_en) begin
                o_en_cnt++; o_en_k = k;
                o_addr = a_mem_addr; o_we = a_mem_we; o_wdata = a_mem_wdata;
            end else if (a_mem_we != 4'b0000) begin
                o_stray_we++;
            end
            if (o_resp_k != 0 && k == o_resp_k + 1) o_ready_after = int'(a_req_ready);
            if (a_resp_valid && o_resp_k == 0) begin
                o_resp_k = k; o_rdata = a_resp_rdata; o_err = a_resp_err;
            end
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_size = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_size = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b expected 1", a_req_ready);
        end
        n_checks++;
        if ({a_resp_valid, a_resp_err, a_mem_en, a_mem_we} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got valid=%b err=%b en=%b we=%b expected all 0",
                     a_resp_valid, a_resp_err, a_mem_en, a_mem_we);
        end
        n_checks++;
        if ({a_mem_addr, a_mem_wdata, a_resp_rdata} !== 96'b0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0",
                     a_mem_addr, a_mem_wdata, a_resp_rdata);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        a_watch(1'b0, 32'h100, SZ_WORD, 32'h0, 32'hDEAD_BEEF);
        n_checks++;
        if (o_en_k !== 1 || o_en_cnt !== 1) begin
            n_errors++; $display("FAIL word_load_en: got cycle %0d count %0d expected cycle 1 count 1", o_en_k, o_en_cnt);
        end
        n_checks++;
        if (o_addr !== 32'h100 || o_we !== 4'b0000) begin
            n_errors++; $display("FAIL word_load_mem: got addr=%h we=%b expected addr=00000100 we=0000", o_addr, o_we);
        end
        n_checks++;
        if (o_resp_k !== 4) begin
            n_errors++; $display("FAIL word_load_resp_cycle: got %0d expected 4", o_resp_k);
        end
        n_checks++;
        if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin
            n_errors++; $display("FAIL word_load_data: got rdata=%h err=%b expected deadbeef err=0", o_rdata, o_err);
        end
        n_checks++;
        if (o_ready_after !== 1) begin
            n_errors++; $display("FAIL word_load_ready_after: got %0d expected 1", o_ready_after);
        end
    endtask

    task automatic test_byte_half_load();
        a_watch(1'b0, 32'h103, SZ_BYTE, 32'h0, 32'h80AA_BBCC);
        n_checks++;
        if (o_rdata !== 32'h0000_0080 || o_resp_k !== 4) begin
            n_errors++; $display("FAIL byte_load: got rdata=%h cycle %0d expected 00000080 cycle 4", o_rdata, o_resp_k);
        end
        n_checks++;
        if (o_addr !== 32'h100) begin
            n_errors++; $display("FAIL byte_load_addr: got %h expected 00000100", o_addr);
        end
        a_watch(1'b0, 32'h102, SZ_HALF, 32'h0, 32'h80AA_BBCC);
        n_checks++;
        if (o_rdata !== 32'h0000_80AA || o_err !== 1'b0) begin
            n_errors++; $display("FAIL half_load: got rdata=%h err=%b expected 000080aa err=0", o_rdata, o_err);
        end
    endtask

    task automatic test_stores();
        a_watch(1'b1, 32'h101, SZ_BYTE, 32'h1234_5678, 32'h0);
        n_checks++;
        if (o_we !== 4'b0010 || o_wdata !== 32'h7878_7878 || o_addr !== 32'h100) begin
            n_errors++; $display("FAIL byte_store_mem: got we=%b wdata=%h addr=%h expected 0010 78787878 00000100", o_we, o_wdata, o_addr);
        end
        n_checks++;
        if (o_resp_k !== 2 || o_en_k !== 1 || o_rdata !== 32'h0) begin
            n_errors++; $display("FAIL byte_store_resp: got resp cycle %0d en cycle %0d rdata=%h expected 2 1 0", o_resp_k, o_en_k, o_rdata);
        end
        n_checks++;
        if (o_stray_we !== 0) begin
            n_errors++; $display("FAIL byte_store_stray_we: got %0d expected 0", o_stray_we);
        end
        a_watch(1'b1, 32'h102, SZ_HALF, 32'h1234_5678, 32'h0);
        n_checks++;
        if (o_we !== 4'b1100 || o_wdata !== 32'h5678_5678) begin
            n_errors++; $display("FAIL half_store_mem: got we=%b wdata=%h expected 1100 56785678", o_we, o_wdata);
        end
    endtask

    task automatic test_misaligned();
        a_watch(1'b0, 32'h102, SZ_WORD, 32'h0, 32'h1234_5678);
        n_checks++;
        if (o_resp_k !== 1 || o_err !== 1'b1) begin
            n_errors++; $display("FAIL misaligned_word: got resp cycle %0d err=%b expected 1 err=1", o_resp_k, o_err);
        end
        n_checks++;
        if (o_en_cnt !== 0 || o_rdata !== 32'h0) begin
            n_errors++; $display("FAIL misaligned_word_mem: got en count %0d rdata=%h expected 0 0", o_en_cnt, o_rdata);
        end
        a_watch(1'b1, 32'h101, SZ_HALF, 32'hFFFF_FFFF, 32'h0);
        n_checks++;
        if (o_resp_k !== 1 || o_err !== 1'b1 || o_en_cnt !== 0) begin
            n_errors++; $display("FAIL misaligned_half: got cycle %0d err=%b en count %0d expected 1 1 0", o_resp_k, o_err, o_en_cnt);
        end
        a_watch(1'b1, 32'h104, SZ_WORD, 32'hAABB_CCDD, 32'h0);
        n_checks++;
        if (o_err !== 1'b0 || o_we !== 4'b1111 || o_wdata !== 32'hAABB_CCDD || o_addr !== 32'h104) begin
            n_errors++; $display("FAIL word_store_after_err: got err=%b we=%b wdata=%h addr=%h expected 0 1111 aabbccdd 00000104", o_err, o_we, o_wdata, o_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n_resp;
        b_mem_data  = 32'hCAFE_F00D;
        b_req_we    = 1'b0;
        b_req_addr  = 32'h200;
        b_req_size  = SZ_WORD;
        b_req_wdata = 32'h1111_1111;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n_checks++;
        if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h200) begin
            n_errors++; $display("FAIL rst_mid_issue: got en=%b addr=%h expected 1 00000200", b_mem_en, b_mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b1;
        #1;
        n_checks++;
        if ({b_mem_en, b_mem_we, b_resp_valid, b_resp_err} !== 7'b0 || b_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_mid_ctrl: got en=%b we=%b valid=%b err=%b ready=%b expected 0 0 0 0 1",
                                 b_mem_en, b_mem_we, b_resp_valid, b_resp_err, b_req_ready);
        end
        n_checks++;
        if ({b_mem_addr, b_mem_wdata, b_resp_rdata} !== 96'b0) begin
            n_errors++; $display("FAIL rst_mid_data: got addr=%h wdata=%h rdata=%h expected 0", b_mem_addr, b_mem_wdata, b_resp_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        @(posedge clk); #1;
        b_req_we    = 1'b1;
        b_req_addr  = 32'h300;
        b_req_wdata = 32'h0BAD_CAFE;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n_checks++;
        if (b_mem_en !== 1'b1 || b_mem_we !== 4'b1111 || b_mem_addr !== 32'h300) begin
            n_errors++; $display("FAIL rst_mid_new_accept: got en=%b we=%b addr=%h expected 1 1111 00000300", b_mem_en, b_mem_we, b_mem_addr);
        end
        n_resp = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (b_resp_valid) n_resp++;
        end
        n_checks++;
        if (n_resp !== 1) begin
            n_errors++; $display("FAIL rst_mid_resp_count: got %0d expected 1", n_resp);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc, n_en, n_resp, last, bad_gap;
        n_acc = 0; n_en = 0; n_resp = 0; last = -1; bad_gap = 0;
        a_req_we    = 1'b1;
        a_req_addr  = 32'h400;
        a_req_size  = SZ_WORD;
        a_req_wdata = 32'h0102_0304;
        a_req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (a_req_valid && a_req_ready) begin
                if (last >= 0 && c - last != 3) bad_gap++;
                last = c;
                n_acc++;
            end
            if (a_mem_en) n_en++;
            if (a_resp_valid) n_resp++;
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (n_acc !== 4 || bad_gap !== 0) begin
            n_errors++; $display("FAIL b2b_accepts: got %0d accepts %0d bad gaps expected 4 accepts 0 bad gaps", n_acc, bad_gap);
        end
        n_checks++;
        if (n_en !== 4) begin
            n_errors++; $display("FAIL b2b_mem_en: got %0d expected 4", n_en);
        end
        n_checks++;
        if (n_resp !== 4) begin
            n_errors++; $display("FAIL b2b_resp: got %0d expected 4", n_resp);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_half_load();
        test_stores();
        test_misaligned();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Sequential data-memory access stage of the lab4 CPU. It takes one load/store request at a time from the execute stage, drives a fixed-latency synchronous data memory with byte enables, and returns the raw read word right-aligned by byte offset. That word goes to the downstream 32-bit load filter, which does sign/zero extension. Misaligned accesses are trapped here and never reach memory.

## Interface
Parameters:
- MEM_LATENCY, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, in low bits
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load: mem word >> (8*addr[1:0]), unmasked; store/error: 0
- resp_err  out  1  misaligned access, valid with resp_valid
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  replicated store data
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE), combinational.
- IDLE: on req_valid&&req_ready, capture we/addr/size/wdata. If aligned, go to ISSUE. If misaligned, go to RESP with err set. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- ISSUE (1 cycle): mem_en=1, plus mem_addr, mem_we and mem_wdata from registers. Store goes to RESP. Load loads the counter with MEM_LATENCY-1 and goes to WAIT. When MEM_LATENCY==1, the load goes to WAIT with a count of 0.
- WAIT: the counter decrements each cycle. When the counter is 0, sample mem_rdata, shift it right by 8*addr[1:0], latch it into resp_rdata, and go to RESP.
- RESP (1 cycle): resp_valid=1, then go to IDLE.
- Store byte enables are 4'b0001<<off for byte, 4'b0011<<off for half, 4'b1111 for word. Store data is {4{wdata[7:0]}}, {2{wdata[15:0]}} or wdata.
- mem_we is 0 whenever mem_en is 0. mem_en is asserted only in ISSUE. Loads drive mem_we=0.
- The counter is 3 bits wide.

## Timing
- Acceptance at cycle T.
- Load: mem_en at T+1. mem_rdata is sampled at T+1+MEM_LATENCY. resp_valid is at T+2+MEM_LATENCY.
- Store: mem_en/mem_we at T+1, resp_valid at T+2.
- Misaligned: resp_valid with resp_err=1 at T+1, and no mem_en.
- req_ready is high again the cycle after resp_valid.
- Minimum spacing between requests is MEM_LATENCY+3 cycles for a load and 3 cycles for a store.
- req_valid while not ready is ignored; there is no queueing.
- Reset values:
  - State is IDLE and req_ready=1.
  - resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr and mem_wdata are all 0.
- Reset mid-operation aborts immediately and asynchronously. mem_en drops at once, and no response is ever produced for the aborted request.
- resp_rdata and resp_err hold their values until the next response. They are only meaningful while resp_valid is high.

## Structure
- Shared package cpu_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state enum
  - alignment-check function
- Sub-module store_align (combinational): size + offset + wdata -> mem_we mask and replicated mem_wdata.
- The FSM, counter and read shifter live in dmem_access_unit.

## Test plan
- Aligned word load, MEM_LATENCY=2, addr 0x100, mem_rdata=0xDEADBEEF -> mem_en at T+1 with mem_addr 0x100, resp_valid at T+4, resp_rdata 0xDEADBEEF, resp_err 0.
- Byte load at addr 0x103, mem_rdata 0x80AABBCC -> resp_rdata 0x00000080.
- Half load at 0x102, same data -> resp_rdata 0x000080AA.
- Stores:
  - byte store at 0x101, wdata 0x12345678 -> mem_we 4'b0010, mem_wdata 0x78787878, resp_valid at T+2.
  - half store at 0x102 -> mem_we 4'b1100, mem_wdata 0x56785678.
- Misaligned word load at 0x102 -> resp_valid and resp_err=1 at T+1, and mem_en stays 0 throughout.
- rst asserted during WAIT (MEM_LATENCY=4) -> outputs go to 0 immediately, no resp_valid ever appears, and a new request is accepted the cycle after rst is released.
- req_valid held high continuously across back-to-back word stores -> accepts every 3rd cycle, with exactly one mem_en per accepted request.
